// File: rtl/status_tx_handshake.sv
// Purpose: queues status words and sends them one at a time to the Pico using a
//          4-phase REQ/ACK handshake, with data setup, ACK sync and timeout recovery.
// Latency: req_out rises SETUP_CYCLES+1 edges after a word is popped into data_out.
// Backpressure: in_ready drops while the FIFO is full; pushes seen then are ignored.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   in_data/in_valid/in_ready  status word push interface
//   ack_in         asynchronous ACK from the Pico
//   data_out/req_out           parallel data bus and REQ towards the Pico
//   busy           transaction in flight or words still queued
//   sent_pulse     one cycle when a word completes its handshake
//   timeout_pulse  one cycle when an ACK phase times out
//   timeout_count  saturating count of timeouts
module status_tx_handshake #(
  parameter int DATA_WIDTH     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_out,
  output logic                  busy,
  output logic                  sent_pulse,
  output logic                  timeout_pulse,
  output logic [7:0]            timeout_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RECOVER
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic pop, push, sent_set, timeout_set;

  // ACK synchroniser; the FSM only ever looks at ack_s.
  logic [SYNC_STAGES-1:0] ack_sync;
  logic ack_s;
  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  // Transmit FIFO with registered full/empty flags.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full, empty;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Handshake FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Handshake FSM: next state and event strobes
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pop         = 1'b0;
    sent_set    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        // A stale ACK keeps the setup count pinned at zero so REQ never
        // rises while the Pico still shows ACK.
        if (ack_s)                   cnt_nxt   = '0;
        else if (cnt == SETUP_LAST)  state_nxt = S_WAIT_HI;
        else                         cnt_nxt   = cnt + CW'(1);
      end
      S_WAIT_HI: begin
        if (ack_s) begin
          state_nxt = S_WAIT_LO;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          state_nxt   = S_RECOVER;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!ack_s) begin
          sent_set  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          state_nxt   = S_RECOVER;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RECOVER: begin
        // Timed-out word is dropped; just wait for the Pico to release ACK.
        if (!ack_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Registered outputs so REQ and the pulses are glitch-free towards the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out      <= '0;
      req_out       <= 1'b0;
      sent_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      if (pop) data_out <= mem[rd_ptr];
      req_out       <= (state_nxt == S_WAIT_HI);
      sent_pulse    <= sent_set;
      timeout_pulse <= timeout_set;
      if (timeout_set && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

  assign busy = (state != S_IDLE) | ~empty;

endmodule
